fifo_uart_tx: RTL and testbench

//  Downstream consumer of the byte FIFO. Pops bytes from a first-word-fall-through FIFO
//  (dout valid whenever !empty) and serialises each one as a UART 8N1 frame on serial_out.
//  It is the transmit half of the FIFO-buffered UART path and sits between the FIFO and the TX pin.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_counter.sv | 34 +++
 rtl/fifo_uart_tx.sv | 107 ++++++++++
 tb/tb_fifo_uart_tx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and baud divisor helper.
// Used by both the TX path and the future RX block.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  function automatic int unsigned clks_per_bit(
    input int unsigned clock_freq,
    input int unsigned baud_rate
  );
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Held at zero while clear is high so every frame starts phase-aligned.
module uart_baud_counter #(
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign bit_done = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_done) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART 8N1 transmitter fed from a first-word-fall-through FIFO.
// Pops one word in IDLE and serialises it LSB first on serial_out.
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 125_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_en,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  output logic                  serial_out,
  output logic                  busy
);

  localparam int unsigned CLKS_PER_BIT =
    clks_per_bit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned BW = $clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  ser_q, ser_d;
  logic                  pop;
  logic                  bit_done;
  logic                  baud_clr;

  assign baud_clr = (state_q == IDLE);

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (baud_clr),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_en && !fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            bit_d   = '0;
            state_d = STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level follows the state being entered, so it is glitch-free.
  always_comb begin
    ser_d = 1'b1;
    unique case (state_d)
      START:   ser_d = 1'b0;
      DATA:    ser_d = shift_d[0];
      default: ser_d = 1'b1;
    endcase
  end

  assign fifo_rd_en = pop && rst_n;
  assign serial_out = ser_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FWFT FIFO model plus frame-timeline reference.
// Every cycle's line, busy and pop strobe are compared to the reference.
module tb_fifo_uart_tx;

  localparam int CPB   = 10;
  localparam int DW    = 8;
  localparam int FRAME = (DW + 2) * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en;
  logic       serial_out;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pops  = 0;
  int pop_cyc[$];
  logic [7:0] q[$];

  bit         checking = 1'b0;
  bit         m_active = 1'b0;
  int         m_k = 0;
  logic [7:0] m_byte = 8'h00;
  logic       s_ser, s_busy, s_rd;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLOCK_FREQ (1000),
    .BAUD_RATE  (100),
    .DATA_WIDTH (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .serial_out (serial_out),
    .busy       (busy)
  );

  // Line level k cycles into a frame carrying byte b.
  function automatic logic bitval(input logic [7:0] b, input int k);
    int slot;
    slot = k / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= DW) return b[slot-1];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic e_rd;
    fifo_empty = (q.size() == 0);
    fifo_dout  = fifo_empty ? 8'($urandom) : q[0];
    #1;
    s_ser  = serial_out;
    s_busy = busy;
    s_rd   = fifo_rd_en;
    e_rd   = rst_n && tx_en && !fifo_empty && !m_active;
    chk("rd_while_empty", 32'(s_rd && fifo_empty), 0);
    if (checking) begin
      chk("serial", 32'(s_ser),
          32'(m_active ? bitval(m_byte, m_k) : 1'b1));
      chk("busy", 32'(s_busy), 32'(m_active));
      chk("rd_en", 32'(s_rd), 32'(e_rd));
    end
    if (!rst_n) begin
      m_active = 1'b0;
    end else if (m_active) begin
      m_k++;
      if (m_k == FRAME) m_active = 1'b0;
    end else if (e_rd) begin
      m_active = 1'b1;
      m_k      = 0;
      m_byte   = q[0];
    end
    @(posedge clk);
    if (s_rd) begin
      pops++;
      pop_cyc.push_back(cyc);
      if (q.size() > 0) void'(q.pop_front());
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic wait_pop(input string name);
    int p0;
    p0 = pops;
    for (int i = 0; i < 300 && pops == p0; i++) tick();
    chk(name, 32'(pops - p0), 1);
  endtask

  initial begin
    logic [9:0] exp_a5;
    int p0, p1, c0, nb;
    exp_a5 = 10'b1101001010;
    @(negedge clk);

    // Reset held with data available and tx_en high.
    rst_n = 1'b0;
    tx_en = 1'b1;
    q.push_back(8'h5A);
    tick();
    checking = 1'b1;
    tick();
    tick();
    chk("rst_no_pop", 32'(pops), 0);
    chk("rst_line", 32'(s_ser), 1);
    q.delete();
    rst_n = 1'b1;
    tx_en = 1'b0;
    tick();
    tick();

    // Reference pinned against the hand-derived 0xA5 frame.
    for (int j = CPB / 2; j < FRAME; j += CPB)
      chk("model_a5", 32'(bitval(8'hA5, j)), 32'(exp_a5[j/CPB]));

    // Single 0xA5 frame sampled mid-bit.
    q.push_back(8'hA5);
    tx_en = 1'b1;
    wait_pop("a5_pop");
    tx_en = 1'b0;
    nb = 0;
    for (int j = 0; j < FRAME + 10; j++) begin
      tick();
      if (s_busy) nb++;
      if (j < FRAME && (j % CPB) == CPB / 2)
        chk("a5_line", 32'(s_ser), 32'(exp_a5[j/CPB]));
    end
    chk("a5_busy_len", 32'(nb), 100);

    // Back-to-back 0x00 / 0xFF.
    p0 = pops;
    c0 = pop_cyc.size();
    q.push_back(8'h00);
    q.push_back(8'hFF);
    tx_en = 1'b1;
    repeat (260) tick();
    chk("b2b_pops", 32'(pops - p0), 2);
    if (pop_cyc.size() >= c0 + 2)
      chk("b2b_spacing", 32'(pop_cyc[c0+1] - pop_cyc[c0]), 101);
    else
      chk("b2b_spacing", 0, 101);
    tx_en = 1'b0;

    // tx_en dropped mid-frame.
    q.push_back(8'h11);
    q.push_back(8'h22);
    q.push_back(8'h33);
    tx_en = 1'b1;
    wait_pop("hold_first_pop");
    repeat (40) tick();
    tx_en = 1'b0;
    p1 = pops;
    repeat (200) tick();
    chk("hold_no_pop", 32'(pops - p1), 0);
    chk("hold_q_left", 32'(q.size()), 2);
    tx_en = 1'b1;
    repeat (250) tick();
    chk("resume_pops", 32'(pops - p1), 2);
    chk("resume_q_empty", 32'(q.size()), 0);

    // Reset 35 cycles into a 0x3C frame.
    q.push_back(8'h3C);
    wait_pop("abort_pop");
    tx_en = 1'b0;
    repeat (35) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("abort_line", 32'(s_ser), 1);
    chk("abort_busy", 32'(s_busy), 0);
    chk("abort_q", 32'(q.size()), 0);

    // Long empty stretch with tx_en high.
    tx_en = 1'b1;
    p1 = pops;
    repeat (1000) tick();
    chk("empty_no_pop", 32'(pops - p1), 0);

    // Random pushes, tx_en toggles and occasional resets.
    repeat (3000) begin
      if ($urandom_range(0, 9) == 0 && q.size() < 6)
        q.push_back(8'($urandom));
      if ($urandom_range(0, 39) == 0) tx_en = ~tx_en;
      rst_n = ($urandom_range(0, 1499) != 0);
      tick();
    end
    rst_n = 1'b1;
    tx_en = 1'b1;
    for (int i = 0; i < 1200 && (q.size() > 0 || m_active); i++)
      tick();
    chk("drain_q", 32'(q.size()), 0);
    chk("drain_idle", 32'(m_active), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
